ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_edge.sv | 38 +++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding and default timing.
// Also used by the keyboard decoder side of the PS/2 port.
package ps2_pkg;

    // 100 us of clock inhibit at 100 MHz
    localparam int PS2_INHIBIT_CYC = 10000;
    // 20 ms from clock release to ACK at 100 MHz
    localparam int PS2_TIMEOUT_CYC = 2000000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5,
        ST_ACK     = 3'd6,
        ST_FINISH  = 3'd7
    } ps2_tx_state_e;

    // PS/2 frames carry odd parity over the 8 data bits
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Flops reset to 1 so an idle (pulled-up) bus never reads as an edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the raw level through the synchronizer and keep one history bit
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK. Chip top forms PS2_x = oe ? 1'b0 : 1'bz.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYC - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYC - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall;

    ps2_tx_state_e   state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall)
    );

    // Data line edges are never needed; only its sampled level matters
    logic unused_data_fall;
    assign unused_data_fall = data_fall;

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d   = tx_data;
                    parity_d  = odd_parity(tx_data);
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + IW'(1);
                // start bit goes out during the last inhibit cycle
                if (inh_cnt_q == INH_START) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    inh_cnt_d = '0;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                        state_d   = ST_PARITY;
                    end else begin
                        data_oe_d = ~shift_q[bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    if (!data_lvl) begin
                        state_d = ST_ACK;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
        endcase

        // device-paced phases share one deadline measured from clock release
        if (state_q inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK}) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_q == TO_LAST) begin
                error_d   = 1'b1;
                done_d    = 1'b0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state, counters and registered line/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;

endmodule
